mem_alu_driver: RTL and testbench

Upstream bus master for the mem_alu block. Takes one operation request (operands A and B plus an opcode) over a valid/ready handshake. It writes the operands and opcode into the mem_alu register file, reads back the opcode to check it, and writes the start register. After a fixed latency it captures the 16-bit result and returns it over a valid/ready response port. It replaces hand-driven bus stimulus and is the single master of the mem_alu bus.

---
 rtl/mem_alu_driver.sv | 144 ++++++++++++++
 tb/tb_mem_alu_driver.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_alu_driver.sv
// Bus master for mem_alu: writes A/B/op, reads op back, starts the ALU, then captures the result.
// Latency: response valid RES_LAT+7 cycles after acceptance (6 on an op readback mismatch).
// Backpressure: one request in flight; req_ready only in IDLE, and the response holds until rsp_ready.
module mem_alu_driver #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int RES_WIDTH  = 16,
  parameter int RES_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  logic [DATA_WIDTH-1:0] req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [RES_WIDTH-1:0]  rsp_res,
  output logic                  rsp_err,
  output logic                  rd_wr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  enable,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic [RES_WIDTH-1:0]  res_out
);

  localparam logic [3:0] LAT_M1 = 4'(RES_LAT - 1);

  typedef enum logic [3:0] {
    IDLE, WR_A, WR_B, WR_OP, RD_OP, CHK, WR_GO, WAIT, RESP
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] a_q, b_q, op_q;
  logic [3:0]            cnt, cnt_nxt;
  logic                  accept;
  logic                  enable_nxt, rd_wr_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] wr_data_nxt;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    enable_nxt  = 1'b0;
    rd_wr_nxt   = 1'b0;
    addr_nxt    = '0;
    wr_data_nxt = '0;

    case (state)
      IDLE:    if (accept) state_nxt = WR_A;
      WR_A:    state_nxt = WR_B;
      WR_B:    state_nxt = WR_OP;
      WR_OP:   state_nxt = RD_OP;
      RD_OP:   state_nxt = CHK;
      CHK:     state_nxt = (rd_data == op_q) ? WR_GO : RESP;
      WR_GO: begin
        state_nxt = WAIT;
        cnt_nxt   = LAT_M1;
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Bus outputs are registered, so they are decoded from the state being entered.
    case (state_nxt)
      WR_A: begin
        enable_nxt  = 1'b1;
        rd_wr_nxt   = 1'b1;
        addr_nxt    = ADDR_WIDTH'(0);
        wr_data_nxt = accept ? req_a : a_q;
      end
      WR_B: begin
        enable_nxt  = 1'b1;
        rd_wr_nxt   = 1'b1;
        addr_nxt    = ADDR_WIDTH'(1);
        wr_data_nxt = b_q;
      end
      WR_OP: begin
        enable_nxt  = 1'b1;
        rd_wr_nxt   = 1'b1;
        addr_nxt    = ADDR_WIDTH'(2);
        wr_data_nxt = op_q;
      end
      RD_OP: begin
        enable_nxt  = 1'b1;
        addr_nxt    = ADDR_WIDTH'(2);
      end
      WR_GO: begin
        enable_nxt  = 1'b1;
        rd_wr_nxt   = 1'b1;
        addr_nxt    = ADDR_WIDTH'(3);
        wr_data_nxt = DATA_WIDTH'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      enable  <= 1'b0;
      rd_wr   <= 1'b0;
      addr    <= '0;
      wr_data <= '0;
      rsp_res <= '0;
      rsp_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      enable  <= enable_nxt;
      rd_wr   <= rd_wr_nxt;
      addr    <= addr_nxt;
      wr_data <= wr_data_nxt;
      if (accept) begin
        a_q  <= req_a;
        b_q  <= req_b;
        op_q <= req_op;
      end
      if (state == CHK && rd_data != op_q) begin
        rsp_err <= 1'b1;
        rsp_res <= '0;
      end
      if (state == WAIT && cnt == 4'd0) begin
        rsp_err <= 1'b0;
        rsp_res <= res_out;
      end
    end
  end

endmodule

// File: tb/tb_mem_alu_driver.sv
// Directed bench for mem_alu_driver: three instances (RES_LAT 2, 1, 15), each with a small mem_alu model.
module tb_mem_alu_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid_v;
  logic [2:0]  rsp_ready_v;
  logic [7:0]  req_a, req_b, req_op;
  logic        corrupt;
  wire  [2:0]  req_ready_v;
  wire  [2:0]  rsp_valid_v;
  wire  [2:0]  rsp_err_v;
  wire  [47:0] rsp_res_v;
  logic [10:0] bus_log [$];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_calc(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    return (op == 8'h00) ? (16'(a) + 16'(b)) : {a, b};
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g
      localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 1 : 15);
      logic        rd_wr, enable;
      logic [1:0]  addr;
      logic [7:0]  wr_data;
      logic [7:0]  rd_data = 8'h00;
      logic [15:0] res_out = 16'h0000;
      logic [7:0]  regs [4];
      int          lat_cnt = 0;
      int          n_start = 0;

      mem_alu_driver #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .RES_WIDTH(16), .RES_LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid_v[gi]),
        .req_ready (req_ready_v[gi]),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid_v[gi]),
        .rsp_ready (rsp_ready_v[gi]),
        .rsp_res   (rsp_res_v[gi*16 +: 16]),
        .rsp_err   (rsp_err_v[gi]),
        .rd_wr     (rd_wr),
        .addr      (addr),
        .enable    (enable),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .res_out   (res_out)
      );

      // mem_alu model: result appears LAT cycles after the start write, garbage before that
      always @(posedge clk) begin
        if (enable && rd_wr) begin
          regs[addr] <= wr_data;
          if (addr == 2'd0) res_out <= 16'hDEAD;
          if (addr == 2'd3) begin
            n_start <= n_start + 1;
            if (LAT == 1) res_out <= alu_calc(regs[0], regs[1], regs[2]);
            else          lat_cnt <= LAT - 1;
          end
        end
        if (enable && !rd_wr) rd_data <= (corrupt && gi == 0) ? 8'h00 : regs[addr];
        if (lat_cnt == 1) begin
          res_out <= alu_calc(regs[0], regs[1], regs[2]);
          lat_cnt <= 0;
        end else if (lat_cnt > 1) begin
          lat_cnt <= lat_cnt - 1;
        end
      end

      if (gi == 0) begin : lg
        always @(posedge clk) if (enable) bus_log.push_back({rd_wr, addr, wr_data});
      end
    end
  endgenerate

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [30:0] snap0();
    return {req_ready_v[0], rsp_valid_v[0], rsp_err_v[0], g[0].enable, g[0].rd_wr,
            g[0].addr, g[0].wr_data, rsp_res_v[15:0]};
  endfunction

  // Called at a negedge. n = cycle offset from the acceptance edge at which rsp_valid is first seen.
  task automatic run(input int idx, input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                     input int stop_cyc, output int n);
    int t;
    req_a = a; req_b = b; req_op = op;
    req_valid_v[idx] = 1'b1;
    t = 0;
    while (!req_ready_v[idx] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("accept_timeout", 0, 1);
    @(negedge clk);
    req_valid_v[idx] = 1'b0;
    req_a = 8'hEE; req_b = 8'hEE; req_op = 8'hEE;
    if (stop_cyc != 0) begin
      repeat (stop_cyc - 1) @(negedge clk);
      n = 0;
      return;
    end
    n = 1;
    while (!rsp_valid_v[idx] && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic handshake(input int idx);
    rsp_ready_v[idx] = 1'b1;
    @(negedge clk);
    rsp_ready_v[idx] = 1'b0;
  endtask

  initial begin
    int n, s0, acc, w3, seen;
    logic [7:0] acc_a [$];
    logic [10:0] exp_log [5];

    reset = 1'b1;
    req_valid_v = '0; rsp_ready_v = '0; corrupt = 1'b0;
    req_a = 8'h00; req_b = 8'h00; req_op = 8'h00;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", 64'(snap0()), 64'({1'b1, 30'b0}));
    reset = 1'b1;
    @(negedge clk);

    // basic operation
    bus_log.delete();
    run(0, 8'h05, 8'h03, 8'h00, 0, n);
    check("basic_lat", n, 9);
    check("basic_res", rsp_res_v[15:0], 16'h0008);
    check("basic_err", rsp_err_v[0], 0);
    exp_log = '{11'h405, 11'h503, 11'h600, 11'h200, 11'h701};
    check("basic_bus_len", bus_log.size(), 5);
    for (int i = 0; i < 5 && i < bus_log.size(); i++) check("basic_bus", bus_log[i], exp_log[i]);

    // response backpressure
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", {rsp_valid_v[0], rsp_err_v[0], rsp_res_v[15:0], req_ready_v[0]},
            {1'b1, 1'b0, 16'h0008, 1'b0});
    end
    rsp_ready_v[0] = 1'b1;
    @(negedge clk);
    rsp_ready_v[0] = 1'b0;
    check("bp_release", {req_ready_v[0], rsp_valid_v[0]}, 2'b10);

    // readback mismatch
    corrupt = 1'b1;
    bus_log.delete();
    s0 = g[0].n_start;
    run(0, 8'h12, 8'h34, 8'h03, 0, n);
    check("mis_lat", n, 6);
    check("mis_err", rsp_err_v[0], 1);
    check("mis_res", rsp_res_v[15:0], 16'h0000);
    check("mis_no_start", g[0].n_start, s0);
    w3 = 0;
    foreach (bus_log[i]) if (bus_log[i][9:8] == 2'd3) w3++;
    check("mis_no_w3", w3, 0);
    handshake(0);
    corrupt = 1'b0;

    run(0, 8'h40, 8'h02, 8'h00, 0, n);
    check("post_mis_res", {rsp_err_v[0], rsp_res_v[15:0]}, {1'b0, 16'h0042});
    handshake(0);

    // reset in WAIT
    run(0, 8'h20, 8'h22, 8'h00, 7, n);
    reset = 1'b0;
    #1;
    check("rst_async", 64'(snap0()), 64'({1'b1, 30'b0}));
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid_v[0]) seen++;
    end
    check("rst_no_rsp", seen, 0);
    run(0, 8'h07, 8'h09, 8'h00, 0, n);
    check("rst_next_lat", n, 9);
    check("rst_next_res", rsp_res_v[15:0], 16'h0010);
    handshake(0);

    // held request with changing data
    bus_log.delete();
    rsp_ready_v[0] = 1'b1;
    acc = 0;
    for (int k = 0; k < 20; k++) begin
      req_a = 8'(8'h10 + k); req_b = 8'(k); req_op = 8'h00;
      req_valid_v[0] = 1'b1;
      if (req_ready_v[0]) begin
        acc++;
        acc_a.push_back(req_a);
      end
      @(negedge clk);
    end
    req_valid_v[0] = 1'b0;
    repeat (15) @(negedge clk);
    rsp_ready_v[0] = 1'b0;
    check("held_acc", acc, 2);
    s0 = 0;
    foreach (bus_log[i]) begin
      if (bus_log[i][10:8] == 3'b100) begin
        if (s0 == 0) check("held_a0", bus_log[i][7:0], 8'h10);
        else         check("held_a1", bus_log[i][7:0], 8'h1A);
        s0++;
      end
    end
    check("held_w0_cnt", s0, 2);
    check("held_res", rsp_res_v[15:0], 16'h0024);

    // latency sweep
    run(1, 8'h21, 8'h13, 8'h00, 0, n);
    check("lat1_lat", n, 8);
    check("lat1_res", rsp_res_v[31:16], 16'h0034);
    handshake(1);
    run(2, 8'h80, 8'h7F, 8'h05, 0, n);
    check("lat15_lat", n, 22);
    check("lat15_res", rsp_res_v[47:32], 16'h807F);
    handshake(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
